// File: rtl/block_adaptive_scaler_if.sv
// Stream bundle for the block-floating-point scaler: sample input,
// scaled output and static configuration.
interface block_adaptive_scaler_if #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 12,
    parameter int EXP_W = 4
);
    logic                    in_valid;
    logic                    in_ready;
    logic signed [IN_W-1:0]  in_data;
    logic                    cfg_fixed_en;
    logic [EXP_W-1:0]        cfg_fixed_shift;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [OUT_W-1:0] out_data;
    logic [EXP_W-1:0]        out_exp;
    logic                    out_last;

    modport master (
        output in_valid, in_data, cfg_fixed_en, cfg_fixed_shift, out_ready,
        input  in_ready, out_valid, out_data, out_exp, out_last
    );

    modport slave (
        input  in_valid, in_data, cfg_fixed_en, cfg_fixed_shift, out_ready,
        output in_ready, out_valid, out_data, out_exp, out_last
    );
endinterface

// File: rtl/block_adaptive_scaler.sv
// Block floating-point scaler: buffers BLK_LEN signed samples, finds the
// block peak magnitude and drains the block with one common right shift
// (optionally rounded) and saturation to OUT_W bits.
module block_adaptive_scaler #(
    parameter int IN_W    = 16,
    parameter int OUT_W   = 12,
    parameter int BLK_LEN = 8,
    parameter int EXP_W   = 4,
    parameter int ROUND   = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    block_adaptive_scaler_if.slave bus
);
    localparam int                IDX_W     = $clog2(BLK_LEN);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(BLK_LEN - 1);
    localparam int unsigned       MAX_ADAPT = IN_W - OUT_W;
    localparam logic [EXP_W-1:0]  MAX_SHIFT = EXP_W'(IN_W - 1);
    localparam logic [IN_W-1:0]   OUT_LIM   = IN_W'(2 ** (OUT_W - 1));
    localparam logic signed [IN_W:0] SAT_HI = (IN_W+1)'(2 ** (OUT_W - 1) - 1);
    localparam logic signed [IN_W:0] SAT_LO = -(IN_W+1)'(2 ** (OUT_W - 1));

    typedef enum logic [1:0] {FILL, CALC, DRAIN} state_e;

    state_e                 state_q, state_d;
    logic [IDX_W-1:0]       wr_idx_q, wr_idx_d;
    logic [IDX_W-1:0]       rd_idx_q, rd_idx_d;
    logic [IN_W-2:0]        peak_q, peak_d;
    logic [EXP_W-1:0]       shift_q, shift_d;
    logic                   fixed_en_q, fixed_en_d;
    logic [EXP_W-1:0]       fixed_shift_q, fixed_shift_d;
    logic signed [IN_W-1:0] buf_q [BLK_LEN];

    logic [IN_W-2:0]        mag;
    logic [EXP_W-1:0]       adapt_shift;
    logic [EXP_W-1:0]       fixed_sel;
    logic                   found;
    logic signed [IN_W-1:0] sel;
    logic signed [IN_W:0]   ext, rnd, sum, shifted;
    logic signed [OUT_W-1:0] sat_val;

    // One's-complement magnitude: -2^(IN_W-1) folds onto 2^(IN_W-1)-1.
    assign mag = bus.in_data[IN_W-2:0] ^ {(IN_W-1){bus.in_data[IN_W-1]}};

    // Smallest shift that brings the peak under the output range.
    always_comb begin
        adapt_shift = EXP_W'(MAX_ADAPT);
        found       = 1'b0;
        for (int unsigned s = 0; s <= MAX_ADAPT; s++) begin
            if (!found && ({1'b0, peak_q >> s} < OUT_LIM)) begin
                adapt_shift = EXP_W'(s);
                found       = 1'b1;
            end
        end
        fixed_sel = (fixed_shift_q > MAX_SHIFT) ? MAX_SHIFT : fixed_shift_q;
    end

    // Scale the sample at the read pointer: widen, round, shift, saturate.
    always_comb begin
        sel = buf_q[rd_idx_q];
        ext = {sel[IN_W-1], sel};
        rnd = '0;
        if (ROUND != 0 && shift_q != '0) begin
            rnd = (IN_W+1)'(1) <<< (shift_q - 1'b1);
        end
        sum     = ext + rnd;
        shifted = sum >>> shift_q;
        if (shifted > SAT_HI) begin
            sat_val = SAT_HI[OUT_W-1:0];
        end else if (shifted < SAT_LO) begin
            sat_val = SAT_LO[OUT_W-1:0];
        end else begin
            sat_val = shifted[OUT_W-1:0];
        end
    end

    // Sample buffer; contents are only meaningful between FILL and DRAIN.
    always_ff @(posedge clk) begin
        if (state_q == FILL && bus.in_valid) begin
            buf_q[wr_idx_q] <= bus.in_data;
        end
    end

    // State and control registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= FILL;
            wr_idx_q      <= '0;
            rd_idx_q      <= '0;
            peak_q        <= '0;
            shift_q       <= '0;
            fixed_en_q    <= 1'b0;
            fixed_shift_q <= '0;
        end else begin
            state_q       <= state_d;
            wr_idx_q      <= wr_idx_d;
            rd_idx_q      <= rd_idx_d;
            peak_q        <= peak_d;
            shift_q       <= shift_d;
            fixed_en_q    <= fixed_en_d;
            fixed_shift_q <= fixed_shift_d;
        end
    end

    // Next-state and control-register updates.
    always_comb begin
        state_d       = state_q;
        wr_idx_d      = wr_idx_q;
        rd_idx_d      = rd_idx_q;
        peak_d        = peak_q;
        shift_d       = shift_q;
        fixed_en_d    = fixed_en_q;
        fixed_shift_d = fixed_shift_q;
        case (state_q)
            FILL: begin
                if (bus.in_valid) begin
                    peak_d = (mag > peak_q) ? mag : peak_q;
                    if (wr_idx_q == LAST_IDX) begin
                        wr_idx_d      = '0;
                        fixed_en_d    = bus.cfg_fixed_en;
                        fixed_shift_d = bus.cfg_fixed_shift;
                        state_d       = CALC;
                    end else begin
                        wr_idx_d = wr_idx_q + 1'b1;
                    end
                end
            end
            CALC: begin
                shift_d = fixed_en_q ? fixed_sel : adapt_shift;
                state_d = DRAIN;
            end
            DRAIN: begin
                if (bus.out_ready) begin
                    if (rd_idx_q == LAST_IDX) begin
                        rd_idx_d = '0;
                        peak_d   = '0;
                        state_d  = FILL;
                    end else begin
                        rd_idx_d = rd_idx_q + 1'b1;
                    end
                end
            end
            default: state_d = FILL;
        endcase
    end

    // Handshake and data outputs decoded from the current state.
    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_data  = '0;
        bus.out_exp   = '0;
        bus.out_last  = 1'b0;
        case (state_q)
            FILL:  bus.in_ready = 1'b1;
            DRAIN: begin
                bus.out_valid = 1'b1;
                bus.out_data  = sat_val;
                bus.out_exp   = shift_q;
                bus.out_last  = (rd_idx_q == LAST_IDX);
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_block_adaptive_scaler.sv
// Directed bench: two scalers (truncate and round) run the same stimulus.
module tb_block_adaptive_scaler;
    localparam int IN_W  = 16;
    localparam int OUT_W = 12;
    localparam int BLK   = 8;
    localparam int EXP_W = 4;

    typedef struct packed {
        logic [0:7][15:0] s;
        logic             fen;
        logic [3:0]       fsh;
        logic [3:0]       e;
        logic [0:7][11:0] d0;
        logic [0:7][11:0] d1;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_vec = 0;
    int   n_err = 0;
    vec_t vecs [5];

    always #5 clk = ~clk;

    block_adaptive_scaler_if #(.IN_W(IN_W), .OUT_W(OUT_W), .EXP_W(EXP_W)) if0 ();
    block_adaptive_scaler_if #(.IN_W(IN_W), .OUT_W(OUT_W), .EXP_W(EXP_W)) if1 ();

    block_adaptive_scaler #(.IN_W(IN_W), .OUT_W(OUT_W), .BLK_LEN(BLK), .EXP_W(EXP_W), .ROUND(0))
        dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
    block_adaptive_scaler #(.IN_W(IN_W), .OUT_W(OUT_W), .BLK_LEN(BLK), .EXP_W(EXP_W), .ROUND(1))
        dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive_in(input logic v, input logic [15:0] d);
        if0.in_valid = v;
        if1.in_valid = v;
        if0.in_data  = d;
        if1.in_data  = d;
    endtask

    task automatic set_ready(input logic r);
        if0.out_ready = r;
        if1.out_ready = r;
    endtask

    // Starts and ends on a falling edge; ends with the DUTs in CALC.
    task automatic send_block(input int vi, input vec_t v);
        if0.cfg_fixed_en    = v.fen;
        if1.cfg_fixed_en    = v.fen;
        if0.cfg_fixed_shift = v.fsh;
        if1.cfg_fixed_shift = v.fsh;
        for (int i = 0; i < BLK; i++) begin
            drive_in(1'b1, v.s[i]);
            chk($sformatf("v%0d in_ready fill %0d", vi, i), int'(if0.in_ready), 1);
            @(negedge clk);
        end
        drive_in(1'b0, 16'h0);
        chk($sformatf("v%0d calc out_valid", vi), int'(if0.out_valid), 0);
        chk($sformatf("v%0d calc in_ready", vi), int'(if1.in_ready), 0);
    endtask

    task automatic drain_block(input int vi, input vec_t v, input int stall_at, input int rst_at);
        int k;
        int budget;
        @(negedge clk);
        chk($sformatf("v%0d first out_valid", vi), int'(if0.out_valid), 1);
        k = 0;
        budget = 0;
        while (k < BLK && budget < 4 * BLK) begin
            if (if0.out_valid && if1.out_valid) begin
                chk($sformatf("v%0d s%0d trunc data", vi, k), int'(if0.out_data), int'($signed(v.d0[k])));
                chk($sformatf("v%0d s%0d round data", vi, k), int'(if1.out_data), int'($signed(v.d1[k])));
                chk($sformatf("v%0d s%0d exp", vi, k), int'(if0.out_exp), int'(v.e));
                chk($sformatf("v%0d s%0d round exp", vi, k), int'(if1.out_exp), int'(v.e));
                chk($sformatf("v%0d s%0d last", vi, k), int'(if0.out_last), (k == BLK - 1) ? 1 : 0);
                chk($sformatf("v%0d s%0d in_ready", vi, k), int'(if0.in_ready), 0);
                if (k == stall_at) begin
                    set_ready(1'b0);
                    drive_in(1'b1, 16'd999);
                    for (int c = 0; c < 5; c++) begin
                        @(negedge clk);
                        chk($sformatf("stall c%0d valid", c), int'(if0.out_valid), 1);
                        chk($sformatf("stall c%0d data", c), int'(if0.out_data), int'($signed(v.d0[k])));
                        chk($sformatf("stall c%0d round data", c), int'(if1.out_data), int'($signed(v.d1[k])));
                        chk($sformatf("stall c%0d exp", c), int'(if0.out_exp), int'(v.e));
                        chk($sformatf("stall c%0d in_ready", c), int'(if0.in_ready), 0);
                    end
                    drive_in(1'b0, 16'h0);
                    set_ready(1'b1);
                end
                if (k == rst_at) begin
                    rst_n = 1'b0;
                    drive_in(1'b1, 16'd1234);
                    #1;
                    chk("reset in drain out_valid", int'(if0.out_valid), 0);
                    chk("reset in drain in_ready", int'(if0.in_ready), 1);
                    chk("reset in drain out_data", int'(if1.out_data), 0);
                    chk("reset in drain out_last", int'(if0.out_last), 0);
                    @(negedge clk);
                    rst_n = 1'b1;
                    drive_in(1'b0, 16'h0);
                    return;
                end
                k++;
            end
            @(negedge clk);
            budget++;
        end
        if (k < BLK) chk($sformatf("v%0d drain timeout", vi), k, BLK);
    endtask

    initial begin
        //          samples                                                   fen   fsh   exp
        vecs[0] = {{16'sd2047, -16'sd2048, 16'sd0, 16'sd1, -16'sd1, 16'sd100, -16'sd100, 16'sd500},
                   1'b0, 4'd0, 4'd0,
                   {12'sd2047, -12'sd2048, 12'sd0, 12'sd1, -12'sd1, 12'sd100, -12'sd100, 12'sd500},
                   {12'sd2047, -12'sd2048, 12'sd0, 12'sd1, -12'sd1, 12'sd100, -12'sd100, 12'sd500}};
        vecs[1] = {{16'sd16000, 16'sd12, -16'sd5, 16'sd0, 16'sd7, -16'sd16000, 16'sd1000, -16'sd1},
                   1'b0, 4'd7, 4'd3,
                   {12'sd2000, 12'sd1, -12'sd1, 12'sd0, 12'sd0, -12'sd2000, 12'sd125, -12'sd1},
                   {12'sd2000, 12'sd2, -12'sd1, 12'sd0, 12'sd1, -12'sd2000, 12'sd125, 12'sd0}};
        vecs[2] = {{-16'sd32768, 16'sd32767, 16'sd0, 16'sd8, -16'sd8, 16'sd24, -16'sd24, 16'sd1},
                   1'b0, 4'd0, 4'd4,
                   {-12'sd2048, 12'sd2047, 12'sd0, 12'sd0, -12'sd1, 12'sd1, -12'sd2, 12'sd0},
                   {-12'sd2048, 12'sd2047, 12'sd0, 12'sd1, 12'sd0, 12'sd2, -12'sd1, 12'sd0}};
        vecs[3] = {{16'sd10000, -16'sd10000, 16'sd400, -16'sd400, 16'sd3, -16'sd3, 16'sd2, -16'sd2},
                   1'b1, 4'd2, 4'd2,
                   {12'sd2047, -12'sd2048, 12'sd100, -12'sd100, 12'sd0, -12'sd1, 12'sd0, -12'sd1},
                   {12'sd2047, -12'sd2048, 12'sd100, -12'sd100, 12'sd1, -12'sd1, 12'sd1, 12'sd0}};
        vecs[4] = {{16'sd32767, -16'sd32768, 16'sd16384, -16'sd16384, 16'sd16383, 16'sd0, -16'sd1, 16'sd1},
                   1'b1, 4'd15, 4'd15,
                   {12'sd0, -12'sd1, 12'sd0, -12'sd1, 12'sd0, 12'sd0, -12'sd1, 12'sd0},
                   {12'sd1, -12'sd1, 12'sd1, 12'sd0, 12'sd0, 12'sd0, 12'sd0, 12'sd0}};

        rst_n = 1'b0;
        drive_in(1'b1, 16'd77);
        set_ready(1'b1);
        if0.cfg_fixed_en = 1'b0;
        if1.cfg_fixed_en = 1'b0;
        if0.cfg_fixed_shift = '0;
        if1.cfg_fixed_shift = '0;
        repeat (2) @(negedge clk);
        chk("reset out_valid", int'(if0.out_valid), 0);
        chk("reset in_ready", int'(if0.in_ready), 1);
        chk("reset out_data", int'(if0.out_data), 0);
        chk("reset out_exp", int'(if1.out_exp), 0);
        chk("reset out_last", int'(if0.out_last), 0);
        drive_in(1'b0, 16'h0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int vi = 0; vi < 5; vi++) begin
            send_block(vi, vecs[vi]);
            drain_block(vi, vecs[vi], -1, -1);
        end

        // Backpressure on the fourth output sample.
        send_block(11, vecs[1]);
        drain_block(11, vecs[1], 3, -1);

        // Reset while the fifth sample is presented, then a clean block.
        send_block(12, vecs[3]);
        drain_block(12, vecs[3], -1, 4);
        send_block(13, vecs[2]);
        drain_block(13, vecs[2], -1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global timeout: got running, expected finished");
        $fatal(1);
    end
endmodule
